restoring_divider_seq: RTL and testbench
========================================

RESTORING_DIVIDER_SEQ -- requirements
Module: restoring_divider_seq

Interface
REQ-001 Parameter: N, default 32, operand/result bit width (supported values 8, 16, 32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a new division; sampled only in IDLE.
REQ-005 dividend  input  N  unsigned numerator; captured on accepted start.
REQ-006 divisor  input  N  unsigned denominator; captured on accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start until DONE is exited.
REQ-008 done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-009 quotient  output  N  unsigned quotient.
REQ-010 remainder  output  N  unsigned remainder.
REQ-011 div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-012 Datapath SHALL use one internal N-bit parallel-prefix subtractor computing A + ~B + 1, where carry-out 1 means no borrow (A >= B), as the only trial-subtract unit.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; after reset the FSM is in IDLE.
REQ-014 IDLE with start=1 SHALL capture the operands, clear the partial remainder R, load the iteration counter with N, and enter RUN.
REQ-015 Each RUN cycle SHALL shift {R, Q} left by one with the dividend MSB entering R; trial = R_shifted - divisor.
REQ-016 The trial SHALL succeed when the subtractor carry-out is 1 or when the bit shifted out of R was 1; the N+1-bit case is covered by that shifted-out bit.
REQ-017 On success, R <= trial and the new Q LSB <= 1; on failure, R <= R_shifted and the Q LSB <= 0.
REQ-018 The counter SHALL decrement once per RUN cycle; after the N-th iteration the FSM enters DONE.
REQ-019 DONE SHALL assert done for exactly one cycle, drive quotient=Q and remainder=R, then return to IDLE.
REQ-020 Latency SHALL be N+1 cycles from the accepting edge to the done cycle, i.e. 33 for N=32.
REQ-021 quotient, remainder and div_by_zero SHALL hold their last values until the next accepted start, which clears div_by_zero.
REQ-022 start SHALL be ignored while busy or in DONE, with no effect on the operation in flight.
REQ-023 start asserted in the same cycle done pulses SHALL NOT be accepted; a start in the following IDLE cycle is accepted.
REQ-024 Divisor 0 without the Configuration feature SHALL run all N iterations, giving quotient = all ones and remainder = dividend.
REQ-025 Dividend < divisor SHALL give quotient = 0 and remainder = dividend.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, R=0 and Q=0.
REQ-027 Reset during RUN SHALL abandon the operation with no done pulse; the first start after rst_n rises is accepted normally.

Configuration
REQ-028 Macro DIV_ZERO_DETECT_EN: when defined, an accepted start with divisor 0 SHALL skip RUN and go directly to DONE. In that case the next cycle has done=1, div_by_zero=1, quotient = all ones and remainder = dividend (latency 1).
REQ-029 Without DIV_ZERO_DETECT_EN, div_by_zero SHALL be tied to 0 and divisor 0 follows REQ-024 with full N+1 latency.

Verification
REQ-030 dividend=100, divisor=7, start one cycle -> done exactly 33 cycles later, quotient=14, remainder=2, busy low after done.
REQ-031 dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0.
REQ-032 dividend=5, divisor=9 -> quotient=0, remainder=5; dividend=0x80000000, divisor=0x80000001 -> quotient=0, remainder=0x80000000.
REQ-033 dividend=123, divisor=0 -> with macro: done 1 cycle later, div_by_zero=1, quotient=0xFFFFFFFF, remainder=123; without macro: done at 33 cycles with the same quotient/remainder and div_by_zero=0.
REQ-034 Start 100/7, then pulse start with 50/5 at cycle 10 and again in the done cycle -> only 14 r2 is produced, with no second done.
REQ-035 Start 100/7, drop rst_n at cycle 15 -> outputs are zero immediately and no done occurs; a new start 50/5 after release -> quotient=10, remainder=0 at 33 cycles.

Source files
------------

// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider: one quotient bit per cycle, N+1 cycles from start to done.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.

module prefix_sub #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);
  logic [W-1:0] g, p, gg, pp, gn, pn;

  // NOTE: blocking '=' is correct inside always_comb; each pass reads the previous level.
  always_comb begin
    g  = a & ~b;
    p  = a ^ ~b;
    gg = g;
    pp = p;
    gg[0] = g[0] | p[0];  // folds the +1 carry-in into bit 0
    gn = '0;
    pn = '0;
    for (int s = 1; s < W; s = s * 2) begin
      gn = gg;
      pn = pp;
      for (int i = s; i < W; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-s]);
        pn[i] = pp[i] & pp[i-s];
      end
      gg = gn;
      pp = pn;
    end
    diff = p ^ {gg[W-2:0], 1'b1};
    cout = gg[W-1];
  end
endmodule

module restoring_divider_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  r, q, d;
  logic [N-1:0]  r_sh, trial, next_r, next_q;
  logic          msb_out, carry, success;

  assign msb_out = r[N-1];
  assign r_sh    = {r[N-2:0], q[N-1]};

  prefix_sub #(.W(N)) u_sub (
    .a    (r_sh),
    .b    (d),
    .diff (trial),
    .cout (carry)
  );

  // A set shifted-out bit means the true partial remainder is >= 2^N > divisor.
  assign success = carry | msb_out;
  assign next_r  = success ? trial : r_sh;
  assign next_q  = {q[N-2:0], success};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef DIV_ZERO_DETECT_EN
  logic dz_q;
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(N);
`ifdef DIV_ZERO_DETECT_EN
            dz_q <= 1'b0;
            if (divisor == '0) begin
              dz_q      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          r   <= next_r;
          q   <= next_q;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= next_q;
            remainder <= next_r;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_restoring_divider_seq.sv
// Directed bench for restoring_divider_seq (N=32): vector table plus start-ignore and reset sequences.

module tb_restoring_divider_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam int  ZLAT = 1;
  localparam bit  ZDZ  = 1'b1;
`else
  localparam int  ZLAT = 33;
  localparam bit  ZDZ  = 1'b0;
`endif

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  restoring_divider_seq #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call right after an accepting edge; counts cycles until done is seen (cycle 1 = first after accept).
  task automatic wait_done(input int budget, output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < budget) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic issue(input logic [31:0] dvd, input logic [31:0] dvs);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int lat, dones;
    bit seen;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          33,   1'b0};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33,   1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33,   1'b0};
    vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,          33,   1'b0};
    vecs[4] = '{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000,  33,   1'b0};
    vecs[5] = '{32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123,        ZLAT, ZDZ};
    vecs[6] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          33,   1'b0};
    vecs[7] = '{32'd0,          32'd5,          32'd0,          32'd0,          33,   1'b0};
    vecs[8] = '{32'd7,          32'd7,          32'd1,          32'd0,          33,   1'b0};
    vecs[9] = '{32'd1000,       32'd10,         32'd100,        32'd0,          33,   1'b0};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q",    64'(quotient), 64'd0);
    check("rst_r",    64'(remainder), 64'd0);
    check("rst_dz",   64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].dvd, vecs[i].dvs);
      wait_done(40, lat, seen);
      check($sformatf("v%0d_seen", i), 64'(seen), 64'd1);
      check($sformatf("v%0d_lat", i),  64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_q", i),    64'(quotient), 64'(vecs[i].q));
      check($sformatf("v%0d_r", i),    64'(remainder), 64'(vecs[i].r));
      check($sformatf("v%0d_dz", i),   64'(div_by_zero), 64'(vecs[i].dz));
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
      check($sformatf("v%0d_idle", i),  64'(busy), 64'd0);
      check($sformatf("v%0d_hold_q", i), 64'(quotient), 64'(vecs[i].q));
    end

    // Starts during RUN and in the done cycle are both ignored.
    issue(32'd100, 32'd7);
    seen = 1'b0; lat = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (done) seen = 1'b1;
      if (lat == 10 || seen) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("ign_seen", 64'(seen), 64'd1);
    check("ign_lat",  64'(lat), 64'd33);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ign_no_done", 64'(dones), 64'd0);
    check("ign_q", 64'(quotient), 64'd14);
    check("ign_r", 64'(remainder), 64'd2);
    check("ign_busy", 64'(busy), 64'd0);

    // Start held from the done cycle into the next IDLE cycle is accepted on the IDLE edge.
    issue(32'd100, 32'd7);
    wait_done(40, lat, seen);
    check("b2b_first", 64'(quotient), 64'd14);
    start = 1'b1; dividend = 32'd20; divisor = 32'd3;
    @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, lat, seen);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_q", 64'(quotient), 64'd6);
    check("b2b_r", 64'(remainder), 64'd2);

    // Reset mid-run abandons the operation.
    issue(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_q", 64'(quotient), 64'd0);
    check("mrst_r", 64'(remainder), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mrst_no_done", 64'(dones), 64'd0);
    issue(32'd50, 32'd5);
    wait_done(40, lat, seen);
    check("mrst_lat", 64'(lat), 64'd33);
    check("mrst_new_q", 64'(quotient), 64'd10);
    check("mrst_new_r", 64'(remainder), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
